kv_filter_table: RTL
====================

// Module: kv_filter_table
// PURPOSE
//  Associative key/status table answering the RX parser's DB requests.
//  Takes {in_key, in_flag, in_valid} from the parser, applies the op, and
//  returns {out_valid, out_flag} a fixed 2 cycles later.
//  out_flag[2:1]==2'b10 (ARREST) makes the parser drop the current packet.
//  Holds NUM_ENTRIES fully associative entries in flops: key plus 2-bit status.
// PARAMETERS
//  KEY_SIZE     96  key width; matches the parser's in_key
//  NUM_ENTRIES  16  table depth; power of 2, 2..64
//  IDX_W        $clog2(NUM_ENTRIES)  entry index width (derived)
// PORTS
//  clk156       in   1            156.25 MHz clock; the only clock
//  eth_rst_n    in   1            asynchronous, active-low reset
//  in_key       in   KEY_SIZE     request key
//  in_flag      in   4            [0]=request, [2:1]=op (01 SUSPECT, 10 ARREST, 11 DELETE), [3]=0
//  in_valid     in   1            request strobe; may be high on any cycle
//  out_valid    out  1            reply strobe; one pulse per accepted request
//  out_flag     out  4            {1'b0, status after op, 1'b1}
//  out_hit      out  1            key was present before the op; valid with out_valid
//  occupancy    out  IDX_W+1      number of valid entries
//  evict_cnt    out  16           count of entries overwritten because the table was full
// BEHAVIOUR
//  Reset (async, eth_rst_n=0): all entries invalid; rr_ptr=0; all outputs 0.
//    No reply is produced for requests in flight at reset.
//  Accept: in_valid && in_flag[0] && in_flag[2:1]!=00. Other requests are ignored: no reply, no state change.
//  Pipeline, no stalls, one request per cycle:
//    C0: request registered into req_*.
//    C1: req_key compared combinationally with all valid entries.
//        Table update and reply registers are written on the C1->C2 edge.
//    C2: out_valid=1 for exactly one cycle.
//    Back-to-back requests see each other's updates; no forwarding logic is needed.
//  Match: entry valid && key == req_key. At most one match is guaranteed by construction.
//  Ops (S=stored status; "reply" is out_flag[2:1]):
//    SUSPECT, miss -> insert with S=01, reply 01, out_hit=0
//    SUSPECT, hit  -> S unchanged, reply S (01, or 10 if already arrested), out_hit=1
//    ARREST,  hit  -> S:=10, reply 10, out_hit=1
//    ARREST,  miss -> no insert, reply 00, out_hit=0
//    DELETE,  hit  -> entry invalidated, reply 00, out_hit=1
//    DELETE,  miss -> no change, reply 00, out_hit=0
//  Insert slot:
//    - Lowest-index invalid entry if one exists; rr_ptr unchanged.
//    - If full: overwrite entry rr_ptr, then rr_ptr++ (wraps NUM_ENTRIES-1 -> 0).
//      evict_cnt++ (saturates at 16'hFFFF); occupancy unchanged.
//  occupancy updates on the same edge as the table: +1 on insert-to-free, -1 on delete-hit.
//    Never exceeds NUM_ENTRIES and never underflows.
//  out_flag and out_hit hold their last values when out_valid=0. Only out_valid qualifies them.
//  Key 0 is a legal key and gets no special handling.
// TESTING
//  1 Reset, then SUSPECT K1=96'h1 -> out_valid at C2; out_flag=4'b0011, out_hit=0, occupancy=1.
//  2 SUSPECT K1 then ARREST K1 on the next cycle -> replies 0011 then 0101;
//    a third SUSPECT K1 -> 0101, out_hit=1.
//  3 ARREST K2 never inserted -> out_flag=4'b0001, out_hit=0, occupancy unchanged.
//  4 Insert 17 distinct keys with NUM_ENTRIES=16
//    -> 17th overwrites entry 0; evict_cnt=1, rr_ptr=1, occupancy=16; first key now misses.
//  5 DELETE a hit then re-SUSPECT the same key -> 0001/hit=1, then 0011/hit=0;
//    key reuses the freed lowest index.
//  6 Assert eth_rst_n=0 one cycle after in_valid
//    -> no out_valid pulse; occupancy=0; a later lookup of that key misses.

Source files
------------

// File: rtl/kv_filter_table.sv
// Fully associative key/status table for the RX parser's DB requests.
// Requests are registered, then looked up and applied; replies appear two cycles after the request.
module kv_filter_table #(
  parameter int unsigned KEY_SIZE    = 96,
  parameter int unsigned NUM_ENTRIES = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                out_hit,
  output logic [IDX_W:0]      occupancy,
  output logic [15:0]         evict_cnt
);

  localparam logic [1:0] OpSuspect = 2'b01;
  localparam logic [1:0] OpArrest  = 2'b10;
  localparam logic [1:0] OpDelete  = 2'b11;

  localparam logic [1:0] StSuspect  = 2'b01;
  localparam logic [1:0] StArrested = 2'b10;

  localparam logic [IDX_W-1:0] IdxOne = 1;
  localparam logic [IDX_W:0]   OccOne = 1;

  // Request stage
  logic                req_valid_q;
  logic [KEY_SIZE-1:0] req_key_q;
  logic [1:0]          req_op_q;

  // Table storage
  logic                ent_valid_q [NUM_ENTRIES];
  logic                ent_valid_d [NUM_ENTRIES];
  logic [KEY_SIZE-1:0] ent_key_q   [NUM_ENTRIES];
  logic [KEY_SIZE-1:0] ent_key_d   [NUM_ENTRIES];
  logic [1:0]          ent_stat_q  [NUM_ENTRIES];
  logic [1:0]          ent_stat_d  [NUM_ENTRIES];

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]   occ_q, occ_d;
  logic [15:0]      evict_q, evict_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ins_idx;
  logic [1:0]       reply_stat;

  logic             accept;
  assign accept = in_valid && in_flag[0] && (in_flag[2:1] != 2'b00);

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      req_valid_q <= 1'b0;
      req_key_q   <= '0;
      req_op_q    <= 2'b00;
    end else begin
      req_valid_q <= accept;
      if (accept) begin
        req_key_q <= in_key;
        req_op_q  <= in_flag[2:1];
      end
    end
  end

  // Match and lowest-free search; at most one entry can match.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && (ent_key_q[i] == req_key_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!ent_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_key_d   = ent_key_q;
    ent_stat_d  = ent_stat_q;
    rr_ptr_d    = rr_ptr_q;
    occ_d       = occ_q;
    evict_d     = evict_q;
    reply_stat  = 2'b00;
    ins_idx     = free_found ? free_idx : rr_ptr_q;
    if (req_valid_q) begin
      case (req_op_q)
        OpSuspect: begin
          if (hit) begin
            reply_stat = ent_stat_q[hit_idx];
          end else begin
            reply_stat           = StSuspect;
            ent_valid_d[ins_idx] = 1'b1;
            ent_key_d[ins_idx]   = req_key_q;
            ent_stat_d[ins_idx]  = StSuspect;
            if (free_found) begin
              occ_d = occ_q + OccOne;
            end else begin
              rr_ptr_d = rr_ptr_q + IdxOne;
              evict_d  = (evict_q == 16'hFFFF) ? evict_q : evict_q + 16'd1;
            end
          end
        end
        OpArrest: begin
          if (hit) begin
            reply_stat          = StArrested;
            ent_stat_d[hit_idx] = StArrested;
          end
        end
        OpDelete: begin
          if (hit) begin
            ent_valid_d[hit_idx] = 1'b0;
            occ_d                = occ_q - OccOne;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_valid_q[i] <= 1'b0;
        ent_key_q[i]   <= '0;
        ent_stat_q[i]  <= 2'b00;
      end
      rr_ptr_q  <= '0;
      occ_q     <= '0;
      evict_q   <= '0;
      out_valid <= 1'b0;
      out_flag  <= 4'b0000;
      out_hit   <= 1'b0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_key_q   <= ent_key_d;
      ent_stat_q  <= ent_stat_d;
      rr_ptr_q    <= rr_ptr_d;
      occ_q       <= occ_d;
      evict_q     <= evict_d;
      out_valid   <= req_valid_q;
      // Reply fields hold between pulses.
      if (req_valid_q) begin
        out_flag <= {1'b0, reply_stat, 1'b1};
        out_hit  <= hit;
      end
    end
  end

  assign occupancy = occ_q;
  assign evict_cnt = evict_q;

endmodule
